// File: rtl/act_arr_pipe.sv
// act_arr_pipe
// Two-stage, valid/ready flow-controlled activation row for the systolic
// output path. Each beat carries SYS_COL signed lanes plus its own
// activation mode and clamp ceiling, so consecutive beats may use different
// modes without draining the pipeline.
//
// Modes: 0 bypass, 1 ReLU, 2 leaky ReLU (arithmetic right shift by
// LEAK_SHIFT), 3 clamped ReLU (ceiling {1'b0, clip_max}).
//
// Optional feature macro: ACT_ARR_PIPE_ZERO_CNT_EN
//    defined   : builds the zero-lane tally and saturating counter
//    undefined : zero_cnt is tied to 0 and zero_cnt_clr is ignored
//
// Ports:
//    clk           clock, rising edge
//    rst           asynchronous active-high reset
//    in_valid      input beat present
//    in_ready      block accepts the beat this cycle
//    in_mode       activation mode for the beat
//    clip_max      unsigned clamp ceiling, travels with the beat
//    in            input lanes
//    out_valid     output beat present
//    out_ready     downstream accepts the beat
//    out           result lanes
//    zero_cnt_clr  synchronous clear of the zero-lane counter
//    zero_cnt      saturating count of lanes forced to zero

module act_arr_pipe #(
   parameter int SYS_COL    = 16,
   parameter int DATA_WIDTH = 32,
   parameter int LEAK_SHIFT = 3,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_mode,
   input  logic [DATA_WIDTH-2:0] clip_max,
   input  logic [DATA_WIDTH-1:0] in [0:SYS_COL-1],
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out [0:SYS_COL-1],
   input  logic                  zero_cnt_clr,
   output logic [CNT_WIDTH-1:0]  zero_cnt
);

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_RELU   = 2'd1,
      MODE_LEAKY  = 2'd2,
      MODE_CLAMP  = 2'd3
   } mode_t;

   logic                  s1_valid;
   mode_t                 s1_mode;
   logic [DATA_WIDTH-2:0] s1_clip;
   logic [DATA_WIDTH-1:0] s1_data [0:SYS_COL-1];
   logic [DATA_WIDTH-1:0] act_lanes [0:SYS_COL-1];
   logic [DATA_WIDTH-1:0] clip_ext;
   logic                  s1_en;
   logic                  s2_en;

   // A stage may advance when it is empty or the stage after it is moving.
   // in_ready therefore depends combinationally on out_ready.
   assign s2_en    = !out_valid || out_ready;
   assign s1_en    = !s1_valid || s2_en;
   assign in_ready = s1_en;
   assign clip_ext = {1'b0, s1_clip};

   // Stage 1 captures the beat with its mode and ceiling; payload registers
   // only load on an actual handshake so idle cycles leave them untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_mode  <= MODE_BYPASS;
         s1_clip  <= '0;
         s1_data  <= '{default: '0};
      end else if (s1_en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_mode <= mode_t'(in_mode);
            s1_clip <= clip_max;
            s1_data <= in;
         end
      end
   end

   // Per-lane activation. Clamp only compares non-negative lanes against a
   // ceiling whose MSB is 0, so an unsigned compare is exact there.
   always_comb begin
      act_lanes = s1_data;
      for (int i = 0; i < SYS_COL; i++) begin
         unique case (s1_mode)
            MODE_RELU: begin
               if (s1_data[i][DATA_WIDTH-1]) act_lanes[i] = '0;
            end
            MODE_LEAKY: begin
               if (s1_data[i][DATA_WIDTH-1])
                  act_lanes[i] = $unsigned($signed(s1_data[i]) >>> LEAK_SHIFT);
            end
            MODE_CLAMP: begin
               if (s1_data[i][DATA_WIDTH-1]) act_lanes[i] = '0;
               else if (s1_data[i] > clip_ext) act_lanes[i] = clip_ext;
            end
            default: begin
            end
         endcase
      end
   end

   // Stage 2 registers the result; it holds while downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out       <= '{default: '0};
      end else if (s2_en) begin
         out_valid <= s1_valid;
         if (s1_valid) out <= act_lanes;
      end
   end

`ifdef ACT_ARR_PIPE_ZERO_CNT_EN
   localparam int ZW    = $clog2(SYS_COL + 1);
   localparam int SUM_W = ((CNT_WIDTH > ZW) ? CNT_WIDTH : ZW) + 1;

   logic [ZW-1:0]        tally;
   logic [ZW-1:0]        beat_zero;
   logic [CNT_WIDTH-1:0] cnt;
   logic [SUM_W-1:0]     cnt_sum;
   logic [SUM_W-1:0]     cnt_max;

   // Lanes forced to zero: negative lanes under ReLU or clamp only.
   always_comb begin
      tally = '0;
      for (int i = 0; i < SYS_COL; i++) begin
         if (s1_data[i][DATA_WIDTH-1] &&
             ((s1_mode == MODE_RELU) || (s1_mode == MODE_CLAMP)))
            tally = tally + ZW'(1);
      end
   end

   // The tally rides in stage 2 alongside its beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) beat_zero <= '0;
      else if (s2_en && s1_valid) beat_zero <= tally;
   end

   // Wide sum so saturation can be detected without wrap.
   always_comb begin
      cnt_max                = '0;
      cnt_max[CNT_WIDTH-1:0] = '1;
      cnt_sum                = SUM_W'(cnt) + SUM_W'(beat_zero);
   end

   // Counter updates on the output handshake; a coincident clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (zero_cnt_clr) cnt <= '0;
      else if (out_valid && out_ready)
         cnt <= (cnt_sum > cnt_max) ? '1 : cnt_sum[CNT_WIDTH-1:0];
   end

   assign zero_cnt = cnt;
`else
   logic unused_zero_cnt_clr;

   assign unused_zero_cnt_clr = zero_cnt_clr;
   assign zero_cnt            = '0;
`endif

endmodule

// File: tb/tb_act_arr_pipe.sv
// tb_act_arr_pipe
// Directed bench for act_arr_pipe: reset and latency, mode sweep,
// backpressure ordering, mixed modes, zero-lane counter, reset mid-stream.
// Counter expectations follow ACT_ARR_PIPE_ZERO_CNT_EN (0 when undefined).

module tb_act_arr_pipe;

   localparam int SYS_COL    = 16;
   localparam int DATA_WIDTH = 32;
   localparam int LEAK_SHIFT = 3;
   localparam int CNT_WIDTH  = 4;

   logic                  clk;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            in_mode;
   logic [DATA_WIDTH-2:0] clip_max;
   logic [DATA_WIDTH-1:0] in_lanes [0:SYS_COL-1];
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_lanes [0:SYS_COL-1];
   logic                  zero_cnt_clr;
   logic [CNT_WIDTH-1:0]  zero_cnt;

   int checks_total  = 0;
   int checks_passed = 0;

   act_arr_pipe #(
      .SYS_COL    (SYS_COL),
      .DATA_WIDTH (DATA_WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT),
      .CNT_WIDTH  (CNT_WIDTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_mode      (in_mode),
      .clip_max     (clip_max),
      .in           (in_lanes),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out          (out_lanes),
      .zero_cnt_clr (zero_cnt_clr),
      .zero_cnt     (zero_cnt)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case anything stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish (actual timeout, required finish)");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected counter value depends on whether the counter is built.
   function automatic int expCnt(input int v);
`ifdef ACT_ARR_PIPE_ZERO_CNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks_total++;
      if (actual == expected) checks_passed++;
      else $display("[TB] FAIL %s: actual %0d, required %0d", tag, actual, expected);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setLanes(input int a0, input int a1, input int a2, input int a3, input int fill);
      for (int i = 0; i < SYS_COL; i++) in_lanes[i] = DATA_WIDTH'(fill);
      in_lanes[0] = DATA_WIDTH'(a0);
      in_lanes[1] = DATA_WIDTH'(a1);
      in_lanes[2] = DATA_WIDTH'(a2);
      in_lanes[3] = DATA_WIDTH'(a3);
   endtask

   task automatic setNeg(input int k);
      for (int i = 0; i < SYS_COL; i++) in_lanes[i] = (i < k) ? -32'sd3 : 32'sd4;
   endtask

   task automatic applyStimulus(input int mode, input int clip);
      in_valid = 1'b1;
      in_mode  = 2'(mode);
      clip_max = (DATA_WIDTH-1)'(clip);
   endtask

   // Drive one beat with out_ready high and let it complete its handshake.
   task automatic passBeat(input int mode, input int clip);
      applyStimulus(mode, clip);
      step();
      in_valid = 1'b0;
      step();
      step();
   endtask

   int exp_sweep [4][4] = '{'{-16, -1, 0, 100},
                            '{  0,  0, 0, 100},
                            '{ -2, -1, 0, 100},
                            '{  0,  0, 0,  50}};
   int exp_mix   [4][3] = '{'{ 25,   0, 25},
                            '{ 90, -32, 30},
                            '{100,  -5, 30},
                            '{110,   0, 30}};
   int mix_mode  [4]    = '{3, 0, 2, 1};
   int mix_clip  [4]    = '{25, 10, 5, 5};
   int sweep_cnt [4]    = '{0, 2, 2, 4};
   bit bp_pat    [8]    = '{1, 0, 0, 1, 0, 1, 1, 1};

   initial begin
      int sent;
      int recv;
      int cyc;
      int held_val;
      bit held;
      bit acc;

      rst          = 1'b1;
      in_valid     = 1'b0;
      in_mode      = 2'd0;
      clip_max     = '0;
      out_ready    = 1'b1;
      zero_cnt_clr = 1'b0;
      setLanes(0, 0, 0, 0, 0);

      // Reset state and two-cycle latency.
      step();
      step();
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_in_ready", int'(in_ready), 1);
      checkOutput("rst_zero_cnt", int'(zero_cnt), 0);
      checkOutput("rst_out_lane0", int'(out_lanes[0]), 0);
      rst = 1'b0;
      step();
      setLanes(7, -5, -5, -5, -5);
      applyStimulus(1, 0);
      step();
      in_valid = 1'b0;
      checkOutput("lat_not_early", int'(out_valid), 0);
      step();
      checkOutput("lat_out_valid", int'(out_valid), 1);
      checkOutput("lat_lane0", int'($signed(out_lanes[0])), 7);
      checkOutput("lat_lane1", int'($signed(out_lanes[1])), 0);
      checkOutput("lat_lane15", int'($signed(out_lanes[15])), 0);
      step();
      checkOutput("lat_drained", int'(out_valid), 0);
      checkOutput("lat_zero_cnt", int'(zero_cnt), expCnt(15));

      // Clear, then sweep all four modes over the same lane values.
      zero_cnt_clr = 1'b1;
      step();
      zero_cnt_clr = 1'b0;
      checkOutput("clr_idle", int'(zero_cnt), 0);
      for (int m = 0; m < 4; m++) begin
         setLanes(-16, -1, 0, 100, 0);
         applyStimulus(m, 50);
         step();
         in_valid = 1'b0;
         step();
         checkOutput($sformatf("sweep%0d_valid", m), int'(out_valid), 1);
         for (int k = 0; k < 4; k++)
            checkOutput($sformatf("sweep%0d_lane%0d", m, k),
                        int'($signed(out_lanes[k])), exp_sweep[m][k]);
         step();
         checkOutput($sformatf("sweep%0d_cnt", m), int'(zero_cnt), expCnt(sweep_cnt[m]));
      end

      // Backpressure: eight tagged bypass beats against a stalling sink.
      sent = 0;
      recv = 0;
      cyc  = 0;
      held = 1'b0;
      held_val = 0;
      while ((recv < 8) && (cyc < 60)) begin
         out_ready = bp_pat[cyc % 8];
         if (sent < 8) begin
            setLanes(sent + 1, 0, 0, 0, 0);
            applyStimulus(0, 0);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (held) begin
            checkOutput("bp_hold_valid", int'(out_valid), 1);
            checkOutput("bp_hold_data", int'(out_lanes[0]), held_val);
         end
         checkOutput("bp_in_ready", int'(in_ready), ((sent - recv) == 2 && !out_ready) ? 0 : 1);
         acc      = in_valid && in_ready;
         held     = out_valid && !out_ready;
         held_val = int'(out_lanes[0]);
         if (out_valid && out_ready) begin
            checkOutput("bp_order", int'(out_lanes[0]), recv + 1);
            recv++;
         end
         if (acc) sent++;
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput("bp_count", recv, 8);
      step();
      checkOutput("bp_no_extra", int'(out_valid), 0);

      // Mixed modes back to back, each with its own ceiling.
      for (int c = 0; c < 6; c++) begin
         if (c < 4) begin
            setLanes(80 + 10 * c, -24 - 8 * c, 30, 0, 0);
            applyStimulus(mix_mode[c], mix_clip[c]);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         checkOutput("mix_in_ready", int'(in_ready), 1);
         if (c >= 2) begin
            checkOutput($sformatf("mix%0d_valid", c - 2), int'(out_valid), 1);
            for (int k = 0; k < 3; k++)
               checkOutput($sformatf("mix%0d_lane%0d", c - 2, k),
                           int'($signed(out_lanes[k])), exp_mix[c - 2][k]);
         end
         step();
      end
      checkOutput("mix_cnt", int'(zero_cnt), expCnt(6));

      // Counter: climb to 14, then saturate at 15.
      setNeg(8);
      passBeat(1, 0);
      checkOutput("cnt_preload", int'(zero_cnt), expCnt(14));
      setNeg(5);
      passBeat(3, 1000);
      checkOutput("cnt_saturate", int'(zero_cnt), expCnt(15));

      // Clear coinciding with a handshake drops that beat's tally.
      setNeg(3);
      applyStimulus(1, 0);
      step();
      in_valid = 1'b0;
      step();
      checkOutput("clr_hs_valid", int'(out_valid), 1);
      zero_cnt_clr = 1'b1;
      step();
      zero_cnt_clr = 1'b0;
      checkOutput("clr_hs_cnt", int'(zero_cnt), 0);

      // Reset with two beats in flight.
      setLanes(11, 0, 0, 0, 0);
      applyStimulus(0, 0);
      step();
      setLanes(22, 0, 0, 0, 0);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      checkOutput("mid_full_ready", int'(in_ready), 0);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_valid", int'(out_valid), 0);
      checkOutput("mid_rst_lane0", int'(out_lanes[0]), 0);
      checkOutput("mid_rst_ready", int'(in_ready), 1);
      step();
      rst       = 1'b0;
      out_ready = 1'b1;
      step();
      checkOutput("mid_no_ghost0", int'(out_valid), 0);
      step();
      checkOutput("mid_no_ghost1", int'(out_valid), 0);
      setLanes(77, 0, 0, 0, 0);
      applyStimulus(0, 0);
      step();
      in_valid = 1'b0;
      checkOutput("post_not_early", int'(out_valid), 0);
      step();
      checkOutput("post_valid", int'(out_valid), 1);
      checkOutput("post_lane0", int'(out_lanes[0]), 77);
      step();

      $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
